// File: rtl/pipe_buffer.sv
// pipe_buffer: elastic pipeline register built on a circular buffer of
// DEPTH words. Valid/ready handshakes on both sides, with in_ready and
// out_valid decoded only from registered state so no combinational path
// crosses the block. A synchronous flush squashes all held words.
module pipe_buffer #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    // A single-entry buffer still gets a 1-bit pointer; it simply never leaves 0.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Pointer advance with wrap at DEPTH-1, so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake decodes: full blocks the producer even if the consumer pops
    // this cycle, which keeps in_ready independent of out_ready.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : RST_VAL;

    // Storage, pointers and occupancy; flush outranks any handshake and
    // leaves stored words untouched since they are unreachable afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RST_VAL;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
